sobel_stream_core: RTL and testbench
====================================

Name: sobel_stream_core

Overview:
Parametrised streaming 3x3 Sobel edge-detection core for the image-processing path, sitting between the UART receiver and the VGA frame store and UART transmitter.
- Generalised over image size and pixel width.
- Holds its own line buffers and raster counters.
- Runtime threshold and output mode (binary edge map or saturated gradient magnitude).
- Frame-restart input and end-of-frame strobe.

Parameters:
IMG_WIDTH, 100, pixels per line (>=3)
IMG_HEIGHT, 100, lines per frame (>=3)
DATA_W, 8, pixel width in and out (4..12)

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
data_in  input  DATA_W  input pixel, raster order
in_flag  input  1  data_in valid, one pulse per pixel
frame_rst  input  1  synchronous pulse: restart raster at pixel (0,0)
mode  input  1  0 = binary edge map, 1 = magnitude
threshold  input  DATA_W  binary-mode threshold
data_out  output  DATA_W  filtered pixel
out_flag  output  1  data_out valid, single-cycle pulse
frame_done  output  1  pulses with the out_flag of the last pixel of a frame

Behaviour:
- Reset (async, sys_rst_n low):
  - data_out=0, out_flag=0, frame_done=0.
  - Column/row counters=0, pipeline valids=0.
  - Line buffer and window contents are don't-care; the validity rules below mask them.
- Accept rule: a pixel is accepted on each cycle with in_flag=1. Back-to-back accepts are legal; no backpressure exists.
- Raster counters:
  - col advances 0..IMG_WIDTH-1 per accept. Wrap to 0 increments row.
  - row wraps IMG_HEIGHT-1 -> 0 after the last pixel.
- Line buffers:
  - Two IMG_WIDTH-deep buffers hold the previous two lines, indexed by col.
  - Each accept shifts column {lb1[col], lb0[col], data_in} into a 3x3 window register. It writes lb1[col]<=lb0[col] and lb0[col]<=data_in.
- Window indexing: after accepting pixel (r,c), the window covers rows r-2..r and cols c-2..c, with centre (r-1,c-1). p[i][j]: i=row 0..2 top-down, j=col 0..2 left-right.
- Window validity: window_ok = (r>=2)&&(c>=2), where r and c are the counters of the accepted pixel.
- Stage 1 (cycle after accept), signed, DATA_W+3 bits:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20)
  - Gy = (p20+2p21+p22)-(p00+2p01+p02)
- Stage 2 (next cycle):
  - mag = |Gx|+|Gy|, unsigned DATA_W+3 bits.
  - mode=1: data_out = min(mag, 2^DATA_W-1).
  - mode=0: data_out = (mag > threshold) ? all-ones : 0. The comparison is strict.
- mode and threshold are sampled at stage 2.
- Latency: out_flag rises exactly 2 cycles after the accepting in_flag, and only if window_ok. The interior output count per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- data_out holds its last value between pulses.
- frame_done: asserted with out_flag for the accept at (IMG_HEIGHT-1, IMG_WIDTH-1).
- frame_rst:
  - Clears the counters.
  - Results already in the pipeline still emerge.
  - If in_flag is high in the same cycle, that pixel is accepted as (0,0) of the new frame.
- Mid-frame reset: all in-flight outputs are dropped. The next accepted pixel is (0,0).

Optional Feature:
SOBEL_BORDER_EN
- Defined:
  - Every accepted pixel produces an out_flag 2 cycles later.
  - Results with window_ok=0 are forced to data_out=0.
  - Output count = IMG_WIDTH*IMG_HEIGHT, which matches the VGA frame store.
  - frame_done is unchanged.
- Undefined: only interior results are emitted, as above.

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6, DATA_W=8 unless noted.
1. Constant frame of 77, mode=1, back-to-back in_flag -> 24 out_flag pulses, all data_out=0; frame_done on the 24th, 2 cycles after the 48th in_flag.
2. Vertical step (cols 0-3=0, cols 4-7=50), mode=1 -> outputs from input cols 4 and 5 are 200, all others 0, in every row r>=2.
3. Same step with 100 instead of 50, mode=1 -> step outputs saturate to 255. Same step as 2 with mode=0: threshold=199 gives 255; threshold=200 gives 0.
4. frame_rst pulsed with in_flag at pixel 20 of frame 1, then a full constant frame -> no out_flag until new row 2, col 2; exactly 24 outputs and one frame_done afterwards.
5. sys_rst_n dropped mid-row 3 with results in flight -> out_flag stays 0 from assertion; after release, the first out_flag follows the 19th accepted pixel.
6. With SOBEL_BORDER_EN and scenario 1 stimulus -> 48 out_flag pulses, each 2 cycles after its in_flag, all 0; frame_done on the 48th.

Source files
------------

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel core with internal line buffers and raster counters.
// Optional SOBEL_BORDER_EN emits a zero result for every border pixel too.
module sobel_stream_core #(
    parameter int IMG_WIDTH  = 100,
    parameter int IMG_HEIGHT = 100,
    parameter int DATA_W     = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_flag,
    input  logic              frame_rst,
    input  logic              mode,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] data_out,
    output logic              out_flag,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int GW = DATA_W + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef logic [DATA_W-1:0]    pix_t;
    typedef logic signed [GW-1:0] grad_t;
    typedef logic [GW-1:0]        mag_t;

    function automatic grad_t ext(input pix_t p);
        return $signed({3'b000, p});
    endfunction

    function automatic grad_t tap3(input pix_t a, input pix_t b, input pix_t c);
        return ext(a) + (ext(b) <<< 1) + ext(c);
    endfunction

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          ok, last;

    pix_t lb0 [IMG_WIDTH];
    pix_t lb1 [IMG_WIDTH];
    pix_t win [3][3];
    pix_t nxt [3][3];

    grad_t gx, gy, gx1, gy1;
    logic  v1, ok1, last1;

    mag_t  ax, ay, mag;
    pix_t  sat, res;
    logic  emit;

    // A frame_rst arriving with a pixel makes that pixel (0,0).
    always_comb begin
        cur_col = frame_rst ? '0 : col;
        cur_row = frame_rst ? '0 : row;
        ok      = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_flag) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end else if (frame_rst) begin
            col <= '0;
            row <= '0;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nxt[i][0] = win[i][1];
            nxt[i][1] = win[i][2];
            nxt[i][2] = win[i][2];
        end
        nxt[0][2] = lb1[cur_col];
        nxt[1][2] = lb0[cur_col];
        nxt[2][2] = data_in;
    end

    // Gradients are taken from the window as it will look after this accept.
    always_comb begin
        gx = tap3(nxt[0][2], nxt[1][2], nxt[2][2])
           - tap3(nxt[0][0], nxt[1][0], nxt[2][0]);
        gy = tap3(nxt[2][0], nxt[2][1], nxt[2][2])
           - tap3(nxt[0][0], nxt[0][1], nxt[0][2]);
    end

    always_ff @(posedge sys_clk) begin
        if (in_flag) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= data_in;
            win          <= nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v1    <= 1'b0;
            ok1   <= 1'b0;
            last1 <= 1'b0;
            gx1   <= '0;
            gy1   <= '0;
        end else begin
            v1    <= in_flag;
            ok1   <= ok;
            last1 <= last;
            gx1   <= gx;
            gy1   <= gy;
        end
    end

    always_comb begin
        ax  = gx1[GW-1] ? mag_t'(-gx1) : mag_t'(gx1);
        ay  = gy1[GW-1] ? mag_t'(-gy1) : mag_t'(gy1);
        mag = ax + ay;
        sat = (|mag[GW-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
        if (mode)
            res = sat;
        else
            res = (mag > {3'b000, threshold}) ? '1 : '0;
`ifdef SOBEL_BORDER_EN
        if (!ok1)
            res = '0;
        emit = v1;
`else
        emit = v1 && ok1;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_out   <= '0;
            out_flag   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_flag   <= emit;
            frame_done <= emit && last1;
            if (emit)
                data_out <= res;
        end
    end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Bench for sobel_stream_core: step-pattern table, random frames vs a
// frame-array Sobel model, frame_rst and async reset sequences.
module tb_sobel_stream_core;

    localparam int W = 8;
    localparam int H = 6;
    localparam int D = 8;
`ifdef SOBEL_BORDER_EN
    localparam int NFRM = W * H;
    localparam bit BORDER = 1'b1;
`else
    localparam int NFRM = (W - 2) * (H - 2);
    localparam bit BORDER = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [D-1:0] data_in = '0;
    logic         in_flag = 1'b0;
    logic         frame_rst = 1'b0;
    logic         mode = 1'b1;
    logic [D-1:0] threshold = '0;
    logic [D-1:0] data_out;
    logic         out_flag;
    logic         frame_done;

    sobel_stream_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(D)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .data_in(data_in),
        .in_flag(in_flag), .frame_rst(frame_rst), .mode(mode),
        .threshold(threshold), .data_out(data_out),
        .out_flag(out_flag), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int data; int last; } exp_t;
    typedef struct { int lo; int hi; bit md; int thr; int step; } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t q[$];
    int   img [H][W];
    int   dcyc [W*H];
    int   mr = 0, mc = 0;
    int   nout = 0, ndone = 0, done_cyc = -1, first_cyc = -1;
    int   cap [64];
    int   ncap = 0;
    vec_t tbl [7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sobel(input int r, input int c, input bit md,
                                 input int thr);
        int gx, gy, m;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        m = iabs(gx) + iabs(gy);
        if (md) return (m > 255) ? 255 : m;
        return (m > thr) ? 255 : 0;
    endfunction

    task automatic accept(input int pix, input bit frst);
        exp_t e;
        bit   okw;
        if (frst) begin mr = 0; mc = 0; end
        img[mr][mc] = pix;
        dcyc[mr*W+mc] = cyc;
        okw = (mr >= 2) && (mc >= 2);
        if (okw || BORDER) begin
            e.due  = cyc + 2;
            e.data = okw ? sobel(mr, mc, mode, int'(threshold)) : 0;
            e.last = (mr == H-1) && (mc == W-1);
            q.push_back(e);
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic send(input int pix, input bit frst);
        @(posedge clk); #1;
        data_in = D'(pix);
        in_flag = 1'b1;
        frame_rst = frst;
        accept(pix, frst);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_flag = 1'b0;
            frame_rst = 1'b0;
        end
    endtask

    task automatic clr_stats();
        nout = 0; ndone = 0; done_cyc = -1; first_cyc = -1; ncap = 0;
    endtask

    // kind 0: constant lo, 1: step lo|hi at col 4, 2: random with gaps
    task automatic send_frame(input int kind, input int lo, input int hi);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (kind == 2 && $urandom_range(0, 3) == 0) idle(1);
                if (kind == 0) send(lo, 1'b0);
                else if (kind == 1) send((c < 4) ? lo : hi, 1'b0);
                else send(int'($urandom_range(0, 255)), 1'b0);
            end
        idle(4);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_out_flag", int'(out_flag), 0);
        end else begin
            while (q.size() > 0 && q[0].due < cyc) begin
                chk("missed_out", 0, 1);
                void'(q.pop_front());
            end
            if (out_flag) begin
                nout++;
                if (first_cyc < 0) first_cyc = cyc;
                if (frame_done) begin ndone++; done_cyc = cyc; end
                cap[ncap % 64] = int'(data_out);
                ncap++;
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_cycle", cyc, e.due);
                    chk("out_data", int'(data_out), e.data);
                    chk("out_frame_done", int'(frame_done), e.last);
                end
            end else if (frame_done) begin
                chk("done_without_flag", 1, 0);
            end
        end
    end

    initial begin
        int k, r, c, req, last_cyc;
        tbl[0] = '{0,   50,  1'b1, 0,   200};
        tbl[1] = '{0,   100, 1'b1, 0,   255};
        tbl[2] = '{0,   50,  1'b0, 199, 255};
        tbl[3] = '{0,   50,  1'b0, 200, 0};
        tbl[4] = '{50,  0,   1'b1, 0,   200};
        tbl[5] = '{10,  40,  1'b0, 100, 255};
        tbl[6] = '{10,  40,  1'b1, 0,   120};

        @(negedge clk);
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_out_flag", int'(out_flag), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        mode = 1'b1;
        clr_stats();
        for (int i = 0; i < W*H; i++) send(77, 1'b0);
        last_cyc = cyc;
        idle(4);
        chk("const_count", nout, NFRM);
        chk("const_done_count", ndone, 1);
        chk("const_done_cycle", done_cyc, last_cyc + 2);

        for (int t = 0; t < 7; t++) begin
            mode = tbl[t].md;
            threshold = D'(tbl[t].thr);
            clr_stats();
            send_frame(1, tbl[t].lo, tbl[t].hi);
            chk("step_count", ncap, NFRM);
            k = 0;
            for (int i = 0; i < W*H; i++) begin
                r = i / W;
                c = i % W;
                if (BORDER || (r >= 2 && c >= 2)) begin
                    req = (r >= 2 && (c == 4 || c == 5)) ? tbl[t].step : 0;
                    if (k < 64) chk("step_vec", cap[k], req);
                    k++;
                end
            end
        end

        for (int f = 0; f < 4; f++) begin
            mode = 1'($urandom_range(0, 1));
            threshold = D'($urandom_range(0, 255));
            clr_stats();
            send_frame(2, 0, 0);
            chk("rand_count", nout, NFRM);
            chk("rand_done", ndone, 1);
        end

        mode = 1'b1;
        for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 255)), 1'b0);
        idle(4);
        clr_stats();
        send(77, 1'b1);
        for (int i = 1; i < W*H; i++) send(77, 1'b0);
        idle(4);
        chk("frst_count", nout, NFRM);
        chk("frst_done", ndone, 1);
        chk("frst_first_cycle", first_cyc, dcyc[BORDER ? 0 : 2*W+2] + 2);

        for (int i = 0; i < 13; i++) send(int'($urandom_range(0, 255)), 1'b0);
        @(posedge clk); #1;
        in_flag = 1'b0;
        frame_rst = 1'b1;
        mr = 0; mc = 0;
        idle(3);
        clr_stats();
        send_frame(2, 0, 0);
        chk("frst_idle_count", nout, NFRM);

        for (int i = 0; i < 3*W+3; i++) send(int'($urandom_range(0, 255)), 1'b0);
        @(posedge clk); #1;
        in_flag = 1'b0;
        rst_n = 1'b0;
        q.delete();
        mr = 0; mc = 0;
        idle(3);
        rst_n = 1'b1;
        clr_stats();
        mode = 1'b1;
        send_frame(2, 0, 0);
        chk("rst_count", nout, NFRM);
        chk("rst_first_cycle", first_cyc, dcyc[BORDER ? 0 : 2*W+2] + 2);
        chk("rst_done", ndone, 1);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
